lsu_req: RTL and testbench
==========================

Name: lsu_req

Overview:
- Memory-stage initiator that turns a pipeline load/store into a VALID/READY transaction toward the load-store unit.
- Aligns store data and generates byte strobes from funct3/addr[1:0], then holds the request stable until READY.
- On a load, captures the returned word and produces the extracted, sign/zero-extended result.
- Stalls the pipeline while a transaction is outstanding; flags misaligned/illegal accesses and bus timeouts instead of hanging.

Parameters:
TIMEOUT_CYC, 1024, cycles in WAIT without READY before abort; 0 disables timeout
CNT_W, $clog2(TIMEOUT_CYC+1), timeout counter width (derived; must not be overridden)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; one clock; reset is synchronous and active-high
i_req  in  1  pipeline presents a memory instruction; held stable while o_stall=1
i_wren  in  1  1=store, 0=load
i_funct3  in  3  RV32I funct3 of the load/store
i_addr  in  32  effective byte address
i_rs2_data  in  32  store source register
o_stall  out  1  freeze pipeline stage
o_ld_data  out  32  formatted load result, valid with o_done
o_done  out  1  one-cycle completion pulse (load, store, or exception)
o_misalign  out  1  exception: misaligned or illegal funct3, with o_done
o_timeout  out  1  exception: no READY within TIMEOUT_CYC, with o_done
o_VALID  out  1  bus request valid
i_READY  in  1  bus responder ready/complete
o_lsu_addr  out  32  word address {addr[31:2],2'b00}
o_st_data  out  32  lane-replicated store data
o_st_strb  out  4  byte strobe
o_lsu_wren  out  1  store indicator
i_ld_data  in  32  bus read word, valid when i_READY=1

Behaviour:
- FSM states: IDLE, WAIT, RESP. Reset → IDLE; all outputs 0 on the next edge after i_rst=1, including mid-transaction (o_VALID drops; the outstanding access is abandoned).
- Legal funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101. Stores use only 000/001/010.
- Illegal: funct3 011/110/111, LBU/LHU with i_wren=1, halfword with addr[0]=1, word with addr[1:0]≠0.
- IDLE, i_req=1, legal access:
  - Register addr/strb/data/wren/funct3/addr[1:0]; next state WAIT.
  - o_stall=1 combinationally in this cycle.
- IDLE, i_req=1, illegal access:
  - Go to RESP with o_misalign=1.
  - No bus transaction; o_VALID stays 0.
- WAIT:
  - o_VALID=1; all bus outputs held constant.
  - o_stall=1; timeout counter increments each cycle.
  - i_READY=1: capture i_ld_data (loads only), go to RESP, counter cleared.
  - Counter reaches TIMEOUT_CYC−1 with i_READY=0: go to RESP with o_timeout=1 and o_ld_data=0.
  - READY has priority over timeout in the same cycle.
- RESP:
  - o_done=1 and o_stall=0 for exactly one cycle; o_VALID=0.
  - Always returns to IDLE, ignoring i_req; this is the completing instruction still present.
- Strobe generation:
  - SB: 4'b0001<<addr[1:0].
  - SH: 4'b0011<<{addr[1],1'b0}.
  - SW: 4'b1111.
  - Loads: 4'b1111 (strobe unused by responder).
- Store data: SB {4{rs2[7:0]}}, SH {2{rs2[15:0]}}, SW rs2.
- Load extract from the captured word:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passthrough.
  - o_ld_data=0 for stores and exceptions.
- Latency:
  - Zero-wait responder: request cycle 0, o_VALID cycle 1, READY cycle 1, o_done cycle 2.
  - In general, o_done = cycle after READY.
- o_ld_data/o_misalign/o_timeout are registered and meaningful only while o_done=1; 0 otherwise.
- Back-to-back: the next request is accepted in the IDLE cycle after RESP; minimum 3 cycles per access.

Test Plan:
- LW addr=0x2004, i_ld_data=0xDEADBEEF, READY same cycle as VALID → o_VALID one cycle, o_lsu_addr=0x2004, o_done cycle 2, o_ld_data=0xDEADBEEF, stall high cycles 0–1.
- LB addr=0x2003 / LBU addr=0x2003, i_ld_data=0x80FF1234 → o_ld_data=0xFFFFFF80 / 0x00000080; LH addr=0x2002 → 0xFFFF80FF.
- SB addr=0x7001 rs2=0x000000A5 → o_st_strb=4'b0010, o_st_data=0xA5A5A5A5, o_lsu_wren=1; SH addr=0x7002 rs2=0x1234 → strb 4'b1100, data 0x12341234.
- SW addr=0x2002 → no o_VALID, o_done+o_misalign one cycle after request; funct3=011 → same; LBU with i_wren=1 → same.
- TIMEOUT_CYC=8, READY never asserted → o_VALID high exactly 8 cycles, then o_done+o_timeout, o_ld_data=0; READY on 8th WAIT cycle → normal completion, o_timeout=0.
- READY delayed 5 cycles with i_ld_data changing before READY → bus outputs stable throughout, captured value is the one at READY. Assert i_rst in WAIT → o_VALID=0 and state IDLE next cycle, no o_done.

Source files
------------

// File: rtl/lsu_req.sv
// Memory-stage load/store initiator: decodes, aligns and issues one VALID/READY access, formats the load result.
// Latency: request cycle 0, o_VALID from cycle 1, o_done the cycle after READY (or after timeout / misalign decode).
// Backpressure: holds the request stable on the bus until i_READY; stalls the pipeline until the o_done cycle.
//
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_req/i_wren/i_funct3/i_addr/i_rs2_data   pipeline memory instruction (held while o_stall=1)
//   o_stall, o_done, o_ld_data, o_misalign, o_timeout   pipeline-side status and result
//   o_VALID/i_READY, o_lsu_addr, o_st_data, o_st_strb, o_lsu_wren, i_ld_data   bus side
module lsu_req #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_wren,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_rs2_data,
    output logic        o_stall,
    output logic [31:0] o_ld_data,
    output logic        o_done,
    output logic        o_misalign,
    output logic        o_timeout,
    output logic        o_VALID,
    input  logic        i_READY,
    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_st_data,
    output logic [3:0]  o_st_strb,
    output logic        o_lsu_wren,
    input  logic [31:0] i_ld_data
);
    // A disabled timeout still needs a 1-bit counter to keep the declarations legal.
    localparam int             CW       = (CNT_W < 1) ? 1 : CNT_W;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t state, state_nxt;

    logic [31:0]   addr_q, st_data_q, word_q;
    logic [3:0]    strb_q;
    logic          wren_q, misalign_q, timeout_q;
    logic [2:0]    funct3_q;
    logic [1:0]    lane_q;
    logic [CW-1:0] cnt;

    logic          illegal, accept, timeout_hit;
    logic [3:0]    strb_d;
    logic [31:0]   st_data_d;

    // Access legality: unknown funct3, unsigned stores, and unaligned half/word.
    always_comb begin
        illegal = 1'b0;
        case (i_funct3)
            3'b000:         illegal = 1'b0;
            3'b001:         illegal = i_addr[0];
            3'b010:         illegal = |i_addr[1:0];
            3'b100, 3'b101: illegal = i_wren | (i_funct3[0] & i_addr[0]);
            default:        illegal = 1'b1;
        endcase
    end

    // Store lane replication and strobes; loads always request the full word.
    always_comb begin
        strb_d    = 4'b1111;
        st_data_d = i_rs2_data;
        if (i_wren) begin
            case (i_funct3[1:0])
                2'b00: begin
                    strb_d    = 4'b0001 << i_addr[1:0];
                    st_data_d = {4{i_rs2_data[7:0]}};
                end
                2'b01: begin
                    strb_d    = 4'b0011 << {i_addr[1], 1'b0};
                    st_data_d = {2{i_rs2_data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    assign accept      = (state == S_IDLE) && i_req;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; READY wins over a timeout in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_req) state_nxt = illegal ? S_RESP : S_WAIT;
            S_WAIT:  if (i_READY || timeout_hit) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request capture, response capture and timeout counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q     <= '0;
            st_data_q  <= '0;
            strb_q     <= '0;
            wren_q     <= 1'b0;
            funct3_q   <= '0;
            lane_q     <= '0;
            word_q     <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            cnt        <= '0;
        end else begin
            if (accept) begin
                misalign_q <= illegal;
                timeout_q  <= 1'b0;
                cnt        <= '0;
                if (!illegal) begin
                    addr_q    <= {i_addr[31:2], 2'b00};
                    st_data_q <= st_data_d;
                    strb_q    <= strb_d;
                    wren_q    <= i_wren;
                    funct3_q  <= i_funct3;
                    lane_q    <= i_addr[1:0];
                end
            end
            if (state == S_WAIT) begin
                if (i_READY) begin
                    cnt <= '0;
                    if (!wren_q) word_q <= i_ld_data;
                end else if (timeout_hit) begin
                    cnt       <= '0;
                    timeout_q <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Load formatting from the captured word
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_fmt;
    always_comb begin
        ld_b = 8'(word_q >> {lane_q, 3'b000});
        ld_h = 16'(word_q >> {lane_q[1], 4'b0000});
        case (funct3_q)
            3'b000:  ld_fmt = {{24{ld_b[7]}}, ld_b};
            3'b001:  ld_fmt = {{16{ld_h[15]}}, ld_h};
            3'b100:  ld_fmt = {24'd0, ld_b};
            3'b101:  ld_fmt = {16'd0, ld_h};
            default: ld_fmt = word_q;
        endcase
    end

    // Outputs; result and exception flags are visible only in the completion cycle.
    always_comb begin
        o_stall    = accept || (state == S_WAIT);
        o_VALID    = (state == S_WAIT);
        o_done     = (state == S_RESP);
        o_misalign = (state == S_RESP) && misalign_q;
        o_timeout  = (state == S_RESP) && timeout_q;
        o_ld_data  = '0;
        if ((state == S_RESP) && !misalign_q && !timeout_q && !wren_q)
            o_ld_data = ld_fmt;
    end

    assign o_lsu_addr = addr_q;
    assign o_st_data  = st_data_q;
    assign o_st_strb  = strb_q;
    assign o_lsu_wren = wren_q;

endmodule

// File: tb/tb_lsu_req.sv
module tb_lsu_req;
    localparam int TO = 8;

    logic        i_clk = 1'b0;
    logic        i_rst, i_req, i_wren, i_READY;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_rs2_data, i_ld_data;
    logic        o_stall, o_done, o_misalign, o_timeout, o_VALID, o_lsu_wren;
    logic [31:0] o_ld_data, o_lsu_addr, o_st_data;
    logic [3:0]  o_st_strb;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    lsu_req #(.TIMEOUT_CYC(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_wren(i_wren),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_rs2_data(i_rs2_data),
        .o_stall(o_stall), .o_ld_data(o_ld_data), .o_done(o_done),
        .o_misalign(o_misalign), .o_timeout(o_timeout), .o_VALID(o_VALID),
        .i_READY(i_READY), .o_lsu_addr(o_lsu_addr), .o_st_data(o_st_data),
        .o_st_strb(o_st_strb), .o_lsu_wren(o_lsu_wren), .i_ld_data(i_ld_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // One access: request in the cycle after the call, READY after dly WAIT cycles
    // (dly >= TO means the responder never answers). Ends after checking the done cycle.
    task automatic run_acc(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rs2, input int dly, input logic [31:0] word);
        int          nb;
        bit          ill, timed;
        logic [31:0] b, h, exp_ld, exp_dat;
        logic [3:0]  exp_strb;

        nb    = 1 << f3[1:0];
        ill   = (f3 == 3'd3) || (f3 > 3'd5) || (wr && f3 > 3'd3) || ((a % nb) != 0);
        timed = !ill && (dly >= TO);

        exp_strb = wr ? 4'(((1 << nb) - 1) << (a % 4)) : 4'hF;
        if (nb == 1)      exp_dat = (rs2 & 32'hFF)   * 32'h01010101;
        else if (nb == 2) exp_dat = (rs2 & 32'hFFFF) * 32'h00010001;
        else              exp_dat = rs2;

        b = (word >> (8 * (a % 4))) & 32'hFF;
        h = (word >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    exp_ld = (b >= 128)   ? b - 32'd256   : b;
            3'd1:    exp_ld = (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    exp_ld = b;
            3'd5:    exp_ld = h;
            default: exp_ld = word;
        endcase
        if (wr || ill || timed) exp_ld = 32'd0;

        tick;
        i_req = 1'b1; i_wren = wr; i_funct3 = f3; i_addr = a; i_rs2_data = rs2;
        i_READY = 1'b0; i_ld_data = $urandom;
        #1;
        chk("req_stall", 64'(o_stall), 64'(1));
        chk("req_valid", 64'(o_VALID), 64'(0));
        chk("req_done",  64'(o_done),  64'(0));

        if (!ill) begin
            for (int n = 0; n < TO; n++) begin
                tick;
                i_READY   = (n == dly);
                i_ld_data = (n == dly) ? word : $urandom;
                #1;
                chk("wait_valid", 64'(o_VALID), 64'(1));
                chk("wait_stall", 64'(o_stall), 64'(1));
                chk("wait_done",  64'(o_done),  64'(0));
                chk("wait_addr",  64'(o_lsu_addr), 64'(a & 32'hFFFF_FFFC));
                chk("wait_ctl",   64'({o_st_strb, o_lsu_wren}), 64'({exp_strb, wr}));
                if (wr) chk("wait_stdat", 64'(o_st_data), 64'(exp_dat));
                if (n == dly) break;
            end
        end

        tick;
        i_READY = 1'b0; i_ld_data = $urandom;
        #1;
        chk("resp_done",     64'(o_done),     64'(1));
        chk("resp_stall",    64'(o_stall),    64'(0));
        chk("resp_valid",    64'(o_VALID),    64'(0));
        chk("resp_misalign", 64'(o_misalign), 64'(ill));
        chk("resp_timeout",  64'(o_timeout),  64'(timed));
        chk("resp_ld_data",  64'(o_ld_data),  64'(exp_ld));
    endtask

    task automatic idle_cycle;
        tick;
        i_req = 1'b0; i_READY = 1'b0;
        #1;
        chk("idle_done",  64'(o_done),  64'(0));
        chk("idle_valid", 64'(o_VALID), 64'(0));
        chk("idle_stall", 64'(o_stall), 64'(0));
        chk("idle_ld",    64'({o_ld_data, o_misalign, o_timeout}), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        i_rst = 1'b1; i_req = 1'b0; i_wren = 1'b0; i_funct3 = 3'd0;
        i_addr = '0; i_rs2_data = '0; i_ld_data = '0; i_READY = 1'b0;
        tick; tick;
        i_rst = 1'b0;
        #1;
        chk("rst_valid", 64'(o_VALID), 64'(0));
        chk("rst_done",  64'(o_done),  64'(0));
        chk("rst_stall", 64'(o_stall), 64'(0));
        chk("rst_flags", 64'({o_misalign, o_timeout, o_lsu_wren}), 64'(0));
        chk("rst_ld",    64'(o_ld_data),  64'(0));
        chk("rst_addr",  64'(o_lsu_addr), 64'(0));
        chk("rst_bus",   64'({o_st_strb, o_st_data}), 64'(0));

        // Directed cases
        run_acc(1'b0, 3'd2, 32'h2004, 32'h0, 0, 32'hDEADBEEF);
        run_acc(1'b0, 3'd0, 32'h2003, 32'h0, 0, 32'h80FF1234);
        run_acc(1'b0, 3'd4, 32'h2003, 32'h0, 1, 32'h80FF1234);
        run_acc(1'b0, 3'd1, 32'h2002, 32'h0, 2, 32'h80FF1234);
        idle_cycle;
        run_acc(1'b1, 3'd0, 32'h7001, 32'h000000A5, 0, 32'h0);
        run_acc(1'b1, 3'd1, 32'h7002, 32'h00001234, 3, 32'h0);
        run_acc(1'b1, 3'd2, 32'h2002, 32'h11223344, 0, 32'h0);
        run_acc(1'b0, 3'd3, 32'h2000, 32'h0, 0, 32'h0);
        run_acc(1'b1, 3'd4, 32'h2000, 32'h0, 0, 32'h0);
        run_acc(1'b0, 3'd2, 32'h3000, 32'h0, 99, 32'h12345678);
        run_acc(1'b0, 3'd2, 32'h3000, 32'h0, TO - 1, 32'hCAFEF00D);
        run_acc(1'b0, 3'd5, 32'h3002, 32'h0, 5, 32'h8001ABCD);
        idle_cycle;

        // Reset while a load is outstanding
        tick;
        i_req = 1'b1; i_wren = 1'b0; i_funct3 = 3'd2; i_addr = 32'h4000;
        tick;
        #1;
        chk("rstw_valid_pre", 64'(o_VALID), 64'(1));
        tick;
        i_rst = 1'b1;
        tick;
        i_rst = 1'b0; i_req = 1'b0;
        #1;
        chk("rstw_valid", 64'(o_VALID), 64'(0));
        chk("rstw_done",  64'(o_done),  64'(0));
        chk("rstw_stall", 64'(o_stall), 64'(0));
        idle_cycle;

        // Randomized accesses, back-to-back or with idle gaps
        for (int t = 0; t < 200; t++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(1) == 1) ra[1:0] = 2'b00;
            run_acc(1'($urandom_range(1)), 3'($urandom_range(7)), ra, $urandom,
                    int'($urandom_range(TO + 1)), $urandom);
            if ($urandom_range(2) == 0) idle_cycle;
        end
        idle_cycle;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
